// File: rtl/multicycle_divider_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
// Optional feature macro: DIVIDER_EARLY_OUT_EN (see multicycle_divider.sv).
package multicycle_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Widest WIDTH the constant helpers below can describe.
  localparam int MAX_WIDTH = 256;

  // Divide-by-zero quotient: all ones in the low w bits.
  function automatic logic [MAX_WIDTH-1:0] div0_quotient(input int w);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
  endfunction

  // Most negative two's-complement value of a w-bit word.
  function automatic logic [MAX_WIDTH-1:0] signed_min(input int w);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/multicycle_divider_if.sv
// Operand/result handshake bundle for multicycle_divider.
interface multicycle_divider_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output in_valid, is_signed, a, b, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  in_valid, is_signed, a, b, out_ready,
    output in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/multicycle_divider_step.sv
// One restoring-division step on the {rem, quo} partial word.
module divider_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] partial_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] partial_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shift in the next dividend bit, subtract if it fits, record the quotient bit.
  always_comb begin
    shifted = partial_i[2*WIDTH-1:WIDTH-1];
    // Remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
    diff    = shifted[WIDTH-1:0] - divisor_i;
    if (shifted >= {1'b0, divisor_i})
      partial_o = {diff, partial_i[WIDTH-2:0], 1'b1};
    else
      partial_o = {shifted[WIDTH-1:0], partial_i[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/multicycle_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, valid/ready on both sides.
// Optional: DIVIDER_EARLY_OUT_EN skips the iteration when |a| < |b|.
module multicycle_divider #(
  parameter int WIDTH = 64
) (
  input logic                 clk,
  input logic                 resetn,
  input logic                 flush,
  multicycle_divider_if.slave io
);
  import multicycle_divider_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [WIDTH-1:0] Q_DIV0 = WIDTH'(div0_quotient(WIDTH));
  localparam logic [WIDTH-1:0] S_MIN  = WIDTH'(signed_min(WIDTH));
  localparam logic [WIDTH-1:0] ZERO   = '0;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // {remainder, quotient}; also serves as the result register in DONE.
  logic [2*WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   fix_quo, fix_rem;
  logic [2*WIDTH-1:0] step_nxt;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (part_q),
    .divisor_i (dvs_q),
    .partial_o (step_nxt)
  );

  // Next-state, operand capture, iteration and sign fixup.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    sa      = io.is_signed & io.a[WIDTH-1];
    sb      = io.is_signed & io.b[WIDTH-1];
    // MIN negates to itself and is then read as an unsigned magnitude.
    abs_a   = sa ? -io.a : io.a;
    abs_b   = sb ? -io.b : io.b;
    fix_quo = neg_quo_q ? -part_q[WIDTH-1:0]       : part_q[WIDTH-1:0];
    fix_rem = neg_rem_q ? -part_q[2*WIDTH-1:WIDTH] : part_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (io.in_valid && !flush) begin
          neg_quo_d = sa ^ sb;
          neg_rem_d = sa;
          dvs_d     = abs_b;
          if (io.b == ZERO) begin
            part_d  = {io.a, Q_DIV0};
            state_d = S_DONE;
          end else if (io.is_signed && io.a == S_MIN && io.b == Q_DIV0) begin
            part_d  = {ZERO, S_MIN};
            state_d = S_DONE;
          end
`ifdef DIVIDER_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            part_d  = {abs_a, ZERO};
            state_d = S_FIX;
          end
`endif
          else begin
            part_d  = {ZERO, abs_a};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        part_d = step_nxt;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        part_d  = {fix_rem, fix_quo};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pipeline redirect wins over every handshake.
    if (flush) state_d = S_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      part_q    <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.quotient  = part_q[WIDTH-1:0];
  assign io.remainder = part_q[2*WIDTH-1:WIDTH];

endmodule
